// File: rtl/dma_tile_scheduler.sv
// dma_tile_scheduler: walks a layer tile by tile, sequencing
// read -> compute -> write through the DMA control block.
module dma_tile_scheduler #(
    parameter int AXI_WIDTH_AD = 32,
    parameter int BIT_TILE     = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    i_cfg_start,
    input  logic [AXI_WIDTH_AD-1:0] i_cfg_base_rd,
    input  logic [AXI_WIDTH_AD-1:0] i_cfg_base_wr,
    input  logic [AXI_WIDTH_AD-1:0] i_cfg_stride_rd,
    input  logic [AXI_WIDTH_AD-1:0] i_cfg_stride_wr,
    input  logic [BIT_TILE-1:0]     i_cfg_num_tiles,
    input  logic [15:0]             i_cfg_blk_rd,
    input  logic [15:0]             i_cfg_blk_wr,
    input  logic                    i_rd_done,
    input  logic                    i_comp_done,
    input  logic                    i_wr_done,
    output logic [1:0]              o_start,
    output logic [AXI_WIDTH_AD-1:0] o_base_address_rd,
    output logic [AXI_WIDTH_AD-1:0] o_base_address_wr,
    output logic [15:0]             o_max_req_blk_idx_rd,
    output logic [15:0]             o_max_req_blk_idx_wr,
    output logic                    o_comp_start,
    output logic [BIT_TILE-1:0]     o_tile_idx,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_err
);

    typedef enum logic [3:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        COMP_ISSUE,
        COMP_WAIT,
        WR_ISSUE,
        WR_WAIT,
        NEXT,
        DONE
    } state_t;

    localparam logic [1:0] START_RD = 2'b10;
    localparam logic [1:0] START_WR = 2'b11;

    state_t                  state_q;
    logic [AXI_WIDTH_AD-1:0] base_rd_q;
    logic [AXI_WIDTH_AD-1:0] base_wr_q;
    logic [AXI_WIDTH_AD-1:0] base_rd_d;
    logic [AXI_WIDTH_AD-1:0] base_wr_d;
    logic [AXI_WIDTH_AD-1:0] stride_rd_q;
    logic [AXI_WIDTH_AD-1:0] stride_wr_q;
    logic [BIT_TILE-1:0]     num_tiles_q;
    logic [BIT_TILE-1:0]     tile_idx_q;
    logic [BIT_TILE-1:0]     tile_idx_d;
    logic [BIT_TILE-1:0]     last_idx;
    logic [15:0]             blk_rd_q;
    logic [15:0]             blk_wr_q;
    logic [1:0]              start_q;
    logic                    comp_start_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    err_q;
    logic                    cfg_ok;

    // Next-tile bases and index; address sums wrap silently.
    always_comb begin
        base_rd_d  = base_rd_q + stride_rd_q;
        base_wr_d  = base_wr_q + stride_wr_q;
        tile_idx_d = tile_idx_q + BIT_TILE'(1);
        last_idx   = num_tiles_q - BIT_TILE'(1);
        cfg_ok     = (i_cfg_num_tiles != '0) &&
                     (i_cfg_blk_rd != '0) &&
                     (i_cfg_blk_wr != '0);
    end

    // Sequencer with pulses registered on the edge entering each state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            base_rd_q    <= '0;
            base_wr_q    <= '0;
            stride_rd_q  <= '0;
            stride_wr_q  <= '0;
            num_tiles_q  <= '0;
            tile_idx_q   <= '0;
            blk_rd_q     <= '0;
            blk_wr_q     <= '0;
            start_q      <= 2'b00;
            comp_start_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            start_q      <= 2'b00;
            comp_start_q <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (i_cfg_start) begin
                        if (cfg_ok) begin
                            base_rd_q   <= i_cfg_base_rd;
                            base_wr_q   <= i_cfg_base_wr;
                            stride_rd_q <= i_cfg_stride_rd;
                            stride_wr_q <= i_cfg_stride_wr;
                            num_tiles_q <= i_cfg_num_tiles;
                            blk_rd_q    <= i_cfg_blk_rd;
                            blk_wr_q    <= i_cfg_blk_wr;
                            tile_idx_q  <= '0;
                            busy_q      <= 1'b1;
                            start_q     <= START_RD;
                            state_q     <= RD_ISSUE;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                RD_ISSUE: state_q <= RD_WAIT;
                RD_WAIT: begin
                    if (i_rd_done) begin
                        comp_start_q <= 1'b1;
                        state_q      <= COMP_ISSUE;
                    end
                end
                COMP_ISSUE: state_q <= COMP_WAIT;
                COMP_WAIT: begin
                    if (i_comp_done) begin
                        start_q <= START_WR;
                        state_q <= WR_ISSUE;
                    end
                end
                WR_ISSUE: state_q <= WR_WAIT;
                WR_WAIT: begin
                    if (i_wr_done) begin
                        state_q <= NEXT;
                    end
                end
                NEXT: begin
                    if (tile_idx_q == last_idx) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        tile_idx_q <= tile_idx_d;
                        base_rd_q  <= base_rd_d;
                        base_wr_q  <= base_wr_d;
                        start_q    <= START_RD;
                        state_q    <= RD_ISSUE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_start              = start_q;
    assign o_base_address_rd    = base_rd_q;
    assign o_base_address_wr    = base_wr_q;
    assign o_max_req_blk_idx_rd = blk_rd_q;
    assign o_max_req_blk_idx_wr = blk_wr_q;
    assign o_comp_start         = comp_start_q;
    assign o_tile_idx           = tile_idx_q;
    assign o_busy               = busy_q;
    assign o_done               = done_q;
    assign o_err                = err_q;

endmodule

// File: tb/tb_dma_tile_scheduler.sv
// tb_dma_tile_scheduler: random layers against a per-layer event model,
// checked by a scoreboard monitor decoupled from the stimulus.
module tb_dma_tile_scheduler;

    localparam int K_RD   = 1;
    localparam int K_COMP = 2;
    localparam int K_WR   = 3;
    localparam int K_DONE = 4;
    localparam int K_ERR  = 5;

    typedef struct {
        int          kind;
        logic [31:0] brd;
        logic [31:0] bwr;
        logic [15:0] tile;
        logic [15:0] blkr;
        logic [15:0] blkw;
    } ev_t;

    logic        clk;
    logic        rstn;
    logic        i_cfg_start;
    logic [31:0] i_cfg_base_rd;
    logic [31:0] i_cfg_base_wr;
    logic [31:0] i_cfg_stride_rd;
    logic [31:0] i_cfg_stride_wr;
    logic [15:0] i_cfg_num_tiles;
    logic [15:0] i_cfg_blk_rd;
    logic [15:0] i_cfg_blk_wr;
    logic        i_rd_done;
    logic        i_comp_done;
    logic        i_wr_done;
    logic [1:0]  o_start;
    logic [31:0] o_base_address_rd;
    logic [31:0] o_base_address_wr;
    logic [15:0] o_max_req_blk_idx_rd;
    logic [15:0] o_max_req_blk_idx_wr;
    logic        o_comp_start;
    logic [15:0] o_tile_idx;
    logic        o_busy;
    logic        o_done;
    logic        o_err;

    ev_t sb[$];
    int  total = 0;
    int  bad = 0;
    int  fixed_lat = -1;
    bit  spur_en = 0;

    dma_tile_scheduler dut (
        .clk                 (clk),
        .rstn                (rstn),
        .i_cfg_start         (i_cfg_start),
        .i_cfg_base_rd       (i_cfg_base_rd),
        .i_cfg_base_wr       (i_cfg_base_wr),
        .i_cfg_stride_rd     (i_cfg_stride_rd),
        .i_cfg_stride_wr     (i_cfg_stride_wr),
        .i_cfg_num_tiles     (i_cfg_num_tiles),
        .i_cfg_blk_rd        (i_cfg_blk_rd),
        .i_cfg_blk_wr        (i_cfg_blk_wr),
        .i_rd_done           (i_rd_done),
        .i_comp_done         (i_comp_done),
        .i_wr_done           (i_wr_done),
        .o_start             (o_start),
        .o_base_address_rd   (o_base_address_rd),
        .o_base_address_wr   (o_base_address_wr),
        .o_max_req_blk_idx_rd(o_max_req_blk_idx_rd),
        .o_max_req_blk_idx_wr(o_max_req_blk_idx_wr),
        .o_comp_start        (o_comp_start),
        .o_tile_idx          (o_tile_idx),
        .o_busy              (o_busy),
        .o_done              (o_done),
        .o_err               (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endfunction

    function automatic int lat();
        if (fixed_lat >= 0) return fixed_lat;
        return $urandom_range(0, 4);
    endfunction

    // Reference model: whole-layer event list from the layer rules.
    task automatic push_model(input logic [31:0] brd, input logic [31:0] bwr,
                              input logic [31:0] srd, input logic [31:0] swr,
                              input logic [15:0] nt, input logic [15:0] br,
                              input logic [15:0] bw);
        ev_t e;
        e.brd = '0; e.bwr = '0; e.tile = '0; e.blkr = br; e.blkw = bw;
        if (nt == 0 || br == 0 || bw == 0) begin
            e.kind = K_ERR;
            sb.push_back(e);
            return;
        end
        for (int t = 0; t < int'(nt); t++) begin
            e.brd  = brd + srd * 32'(t);
            e.bwr  = bwr + swr * 32'(t);
            e.tile = 16'(t);
            e.kind = K_RD;   sb.push_back(e);
            e.kind = K_COMP; sb.push_back(e);
            e.kind = K_WR;   sb.push_back(e);
        end
        e.kind = K_DONE;
        sb.push_back(e);
    endtask

    // Monitor: pop and compare whenever the DUT presents any pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (rstn && (o_start != 2'b00 || o_comp_start || o_done || o_err)) begin
                ev_t ex;
                int  k;
                if (o_start == 2'b10) k = K_RD;
                else if (o_start == 2'b11) k = K_WR;
                else if (o_comp_start) k = K_COMP;
                else if (o_done) k = K_DONE;
                else if (o_err) k = K_ERR;
                else k = 0;
                chk("start_comp_excl", 64'(o_start != 2'b00 && o_comp_start), 0);
                if (sb.size() == 0) begin
                    chk("unexpected_event", 64'(k), 0);
                end else begin
                    ex = sb.pop_front();
                    chk("event_kind", 64'(k), 64'(ex.kind));
                    if (k == ex.kind) begin
                        if (k == K_ERR) begin
                            chk("err_busy", 64'(o_busy), 0);
                        end else begin
                            chk("busy", 64'(o_busy), 1);
                            chk("tile_idx", 64'(o_tile_idx), 64'(ex.tile));
                        end
                        if (k == K_RD || k == K_WR || k == K_DONE) begin
                            chk("base_rd", 64'(o_base_address_rd), 64'(ex.brd));
                            chk("base_wr", 64'(o_base_address_wr), 64'(ex.bwr));
                        end
                        if (k == K_RD || k == K_WR) begin
                            chk("blk_rd", 64'(o_max_req_blk_idx_rd), 64'(ex.blkr));
                            chk("blk_wr", 64'(o_max_req_blk_idx_wr), 64'(ex.blkw));
                        end
                    end
                end
            end
        end
    end

    // Responder: emulates the DMA/array done pulses, plus stray pulses.
    initial begin
        int prd;
        int pcp;
        int pwr;
        prd = -1; pcp = -1; pwr = -1;
        i_rd_done = 1'b0; i_comp_done = 1'b0; i_wr_done = 1'b0;
        forever begin
            @(negedge clk);
            i_rd_done = 1'b0; i_comp_done = 1'b0; i_wr_done = 1'b0;
            if (!rstn) begin
                prd = -1; pcp = -1; pwr = -1;
            end else begin
                if (prd == 0) begin i_rd_done = 1'b1; prd = -1; end
                else if (prd > 0) prd--;
                if (pcp == 0) begin i_comp_done = 1'b1; pcp = -1; end
                else if (pcp > 0) pcp--;
                if (pwr == 0) begin i_wr_done = 1'b1; pwr = -1; end
                else if (pwr > 0) pwr--;
                if (o_start == 2'b10) prd = lat();
                if (o_comp_start) pcp = lat();
                if (o_start == 2'b11) pwr = lat();
                if (spur_en && $urandom_range(0, 3) == 0) begin
                    case ($urandom_range(0, 2))
                        0: if (prd < 0) i_rd_done = 1'b1;
                        1: if (pcp < 0) i_comp_done = 1'b1;
                        default: if (pwr < 0) i_wr_done = 1'b1;
                    endcase
                end
            end
        end
    end

    task automatic start_layer(input logic [31:0] brd, input logic [31:0] bwr,
                               input logic [31:0] srd, input logic [31:0] swr,
                               input logic [15:0] nt, input logic [15:0] br,
                               input logic [15:0] bw);
        push_model(brd, bwr, srd, swr, nt, br, bw);
        @(negedge clk);
        i_cfg_base_rd = brd; i_cfg_base_wr = bwr;
        i_cfg_stride_rd = srd; i_cfg_stride_wr = swr;
        i_cfg_num_tiles = nt; i_cfg_blk_rd = br; i_cfg_blk_wr = bw;
        i_cfg_start = 1'b1;
        @(negedge clk);
        i_cfg_start = 1'b0;
    endtask

    task automatic wait_end(input bit spur);
        int cyc;
        int st;
        st = 0;
        for (cyc = 0; cyc < 1000; cyc++) begin
            if (o_done || o_err) break;
            if (st == 1) begin
                i_cfg_base_rd = $urandom; i_cfg_base_wr = $urandom;
                i_cfg_stride_rd = $urandom; i_cfg_stride_wr = $urandom;
                i_cfg_num_tiles = 16'($urandom_range(1, 9));
                i_cfg_blk_rd = 16'($urandom_range(1, 999));
                i_cfg_blk_wr = 16'($urandom_range(1, 999));
                i_cfg_start = 1'b1;
                st = 2;
            end else if (spur && st == 0 && o_comp_start) begin
                st = 1;
            end
            @(negedge clk);
            i_cfg_start = 1'b0;
        end
        chk("layer_end_timeout", 64'(cyc < 1000), 1);
        repeat (2) @(negedge clk);
        chk("busy_after_layer", 64'(o_busy), 0);
        chk("scoreboard_empty", 64'(sb.size()), 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".start"}, 64'(o_start), 0);
        chk({tag, ".base_rd"}, 64'(o_base_address_rd), 0);
        chk({tag, ".base_wr"}, 64'(o_base_address_wr), 0);
        chk({tag, ".blk_rd"}, 64'(o_max_req_blk_idx_rd), 0);
        chk({tag, ".blk_wr"}, 64'(o_max_req_blk_idx_wr), 0);
        chk({tag, ".comp_start"}, 64'(o_comp_start), 0);
        chk({tag, ".tile_idx"}, 64'(o_tile_idx), 0);
        chk({tag, ".busy"}, 64'(o_busy), 0);
        chk({tag, ".done"}, 64'(o_done), 0);
        chk({tag, ".err"}, 64'(o_err), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        rstn = 1'b0;
        i_cfg_start = 1'b0;
        i_cfg_base_rd = '0; i_cfg_base_wr = '0;
        i_cfg_stride_rd = '0; i_cfg_stride_wr = '0;
        i_cfg_num_tiles = '0; i_cfg_blk_rd = '0; i_cfg_blk_wr = '0;
        #22 rstn = 1'b1;
        @(negedge clk);
        chk_zero("reset");

        fixed_lat = 5;
        start_layer(32'h1000, 32'h8000, 32'h0, 32'h0, 16'd1, 16'd4, 16'd4);
        wait_end(0);

        fixed_lat = 0;
        start_layer(32'h1000, 32'h8000, 32'h400, 32'h100, 16'd3, 16'd4, 16'd4);
        wait_end(0);

        fixed_lat = -1;
        start_layer(32'h1000, 32'h8000, 32'h400, 32'h100, 16'd0, 16'd4, 16'd4);
        wait_end(0);
        start_layer(32'h1000, 32'h8000, 32'h400, 32'h100, 16'd2, 16'd4, 16'd0);
        wait_end(0);

        spur_en = 1'b1;
        start_layer(32'h3000, 32'h7000, 32'h40, 32'h80, 16'd2, 16'd7, 16'd9);
        wait_end(1);

        start_layer(32'hFFFF_FC00, 32'h5000, 32'h400, 32'h10, 16'd2, 16'd1, 16'd1);
        wait_end(0);

        start_layer(32'h2000, 32'h9000, 32'h40, 32'h80, 16'd3, 16'd8, 16'd8);
        for (cyc = 0; cyc < 1000; cyc++) begin
            if (o_start == 2'b11 && o_tile_idx == 16'd1) break;
            @(negedge clk);
        end
        chk("reach_tile1_write", 64'(cyc < 1000), 1);
        @(negedge clk);
        #2 rstn = 1'b0;
        #1 chk_zero("midreset");
        sb.delete();
        @(negedge clk);
        #2 rstn = 1'b1;
        start_layer(32'h4000, 32'hA000, 32'h200, 32'h300, 16'd3, 16'd5, 16'd6);
        wait_end(1);

        for (int k = 0; k < 14; k++) begin
            logic [15:0] nt;
            logic [15:0] br;
            logic [15:0] bw;
            int          inv;
            nt  = 16'($urandom_range(1, 4));
            br  = 16'($urandom_range(1, 65535));
            bw  = 16'($urandom_range(1, 65535));
            inv = $urandom_range(0, 6);
            if (inv == 0) nt = '0;
            else if (inv == 1) br = '0;
            else if (inv == 2) bw = '0;
            start_layer($urandom, $urandom, $urandom, $urandom, nt, br, bw);
            wait_end(1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
